// File: rtl/adder_pkg.sv
// adder_pkg: shared definitions for the pipelined adder.
//   slice_width()  - bits resolved per pipeline stage (WIDTH / STAGES)
//   params_legal() - legal WIDTH/STAGES combination check
package adder_pkg;

    localparam int MIN_WIDTH  = 2;
    localparam int MAX_WIDTH  = 64;
    localparam int MIN_STAGES = 1;
    localparam int MAX_STAGES = 8;

    function automatic int slice_width(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic bit params_legal(input int width, input int stages);
        return (width >= MIN_WIDTH) && (width <= MAX_WIDTH) &&
               (stages >= MIN_STAGES) && (stages <= MAX_STAGES) &&
               ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// pipelined_adder_if: operand/result handshake bundle for pipelined_adder.
//   in_valid/in_ready   - operand beat handshake
//   in_a, in_b          - operands (WIDTH bits)
//   in_cin, in_sub      - carry-in, subtract request
//   out_valid/out_ready - result beat handshake
//   out_sum, out_cout   - result bits, carry-out of MSB
//   out_ovf             - signed overflow
// master: beat source / result sink side. slave: the adder.
interface pipelined_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );
endinterface

// File: rtl/adder_slice.sv
// adder_slice: W-bit ripple-carry adder built from full adders.
//   a, b - slice operands
//   cin  - carry into bit 0
//   sum  - slice sum
//   cout - carry out of bit W-1
module adder_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    logic c;

    always_comb begin
        sum = '0;
        c   = cin;
        for (int i = 0; i < W; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end
endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: carry-pipelined adder, STAGES slices of WIDTH/STAGES bits.
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - pipelined_adder_if.slave (operand and result handshakes)
// Stage k adds slice k and registers its carry, the already-resolved low
// sum bits and the still-unresolved high operand bits for stage k+1.
// Optional feature: define PIPELINED_ADDER_SUB_EN to honour in_sub
// (a - b as a + ~b + 1); otherwise in_sub is ignored and every beat adds.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic              clk,
    input  logic              rst,
    pipelined_adder_if.slave  bus
);
    localparam int W = slice_width(WIDTH, STAGES);

    if (!params_legal(WIDTH, STAGES)) begin : g_bad_params
        $error("pipelined_adder: illegal WIDTH/STAGES combination");
    end

    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

`ifdef PIPELINED_ADDER_SUB_EN
    assign b_eff   = bus.in_sub ? ~bus.in_b : bus.in_b;
    assign cin_eff = bus.in_sub ? 1'b1 : bus.in_cin;
`else
    logic unused_sub;
    assign unused_sub = bus.in_sub;
    assign b_eff      = bus.in_b;
    assign cin_eff    = bus.in_cin;
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // operand bits [WIDTH-1 : k*W] entering this stage
        localparam int UP = WIDTH - k * W;

        logic [UP-1:0]      a_up;
        logic [UP-1:0]      b_up;
        logic               c_in;
        logic               v_in;
        logic [(k+1)*W-1:0] s_nxt;
        logic [W-1:0]       slice_sum;
        logic               slice_cout;
        logic               adv;
        logic               v_q;
        logic               c_q;
        logic [(k+1)*W-1:0] s_q;

        if (k == 0) begin : g_first
            assign a_up  = bus.in_a;
            assign b_up  = b_eff;
            assign c_in  = cin_eff;
            assign v_in  = bus.in_valid;
            assign s_nxt = slice_sum;
        end else begin : g_next
            assign a_up  = g_stage[k-1].g_upper.a_q;
            assign b_up  = g_stage[k-1].g_upper.b_q;
            assign c_in  = g_stage[k-1].c_q;
            assign v_in  = g_stage[k-1].v_q;
            assign s_nxt = {slice_sum, g_stage[k-1].s_q};
        end

        // A stage may load when it is empty or its contents move on.
        if (k == STAGES - 1) begin : g_adv_last
            assign adv = !v_q || bus.out_ready;
        end else begin : g_adv_mid
            assign adv = !v_q || g_stage[k+1].adv;
        end

        adder_slice #(.W(W)) u_slice (
            .a    (a_up[W-1:0]),
            .b    (b_up[W-1:0]),
            .cin  (c_in),
            .sum  (slice_sum),
            .cout (slice_cout)
        );

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (adv) begin
                v_q <= v_in;
                if (v_in) begin
                    c_q <= slice_cout;
                    s_q <= s_nxt;
                end
            end
        end

        if (k < STAGES - 1) begin : g_upper
            logic [UP-W-1:0] a_q;
            logic [UP-W-1:0] b_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv && v_in) begin
                    a_q <= a_up[UP-1:W];
                    b_q <= b_up[UP-1:W];
                end
            end
        end else begin : g_last
            logic ovf_q;

            // a^b^sum at the MSB recovers the carry into the MSB.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (adv && v_in) begin
                    ovf_q <= a_up[W-1] ^ b_up[W-1] ^ slice_sum[W-1] ^ slice_cout;
                end
            end
        end
    end

    assign bus.in_ready  = g_stage[0].adv;
    assign bus.out_valid = g_stage[STAGES-1].v_q;
    assign bus.out_sum   = g_stage[STAGES-1].s_q;
    assign bus.out_cout  = g_stage[STAGES-1].c_q;
    assign bus.out_ovf   = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed checks on a 16/4 adder plus randomised
// traffic on 8/1, 16/4 and 32/8 instances against a behavioural model.
module tb_pipelined_adder;

`ifdef PIPELINED_ADDER_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    localparam int NBEATS = 10000;

    logic clk;
    logic rst;
    bit   rnd_go;
    int   n_checks;
    int   n_errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // directed instance
    pipelined_adder_if #(.WIDTH(16)) bif ();

    pipelined_adder #(.WIDTH(16), .STAGES(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    // randomised instances
    for (genvar g = 0; g < 3; g++) begin : g_rnd
        localparam int RW = (g == 0) ? 8 : (g == 1) ? 16 : 32;
        localparam int RS = (g == 0) ? 1 : (g == 1) ? 4 : 8;

        bit done_flag;

        pipelined_adder_if #(.WIDTH(RW)) rif ();

        pipelined_adder #(.WIDTH(RW), .STAGES(RS)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (rif)
        );

        initial begin : p_rnd
            logic [RW-1:0] ra, rb, beff;
            logic          rc, rs, cin_eff, ovf, held;
            logic [RW:0]   full;
            logic [RW+1:0] exp_q[$];
            logic [RW+1:0] exp_v, got_v;
            logic [RW+2:0] cur_v, held_v;
            int            sent, got, cyc;

            done_flag     = 1'b0;
            rif.in_valid  = 1'b0;
            rif.in_a      = '0;
            rif.in_b      = '0;
            rif.in_cin    = 1'b0;
            rif.in_sub    = 1'b0;
            rif.out_ready = 1'b0;
            held          = 1'b0;
            held_v        = '0;
            sent = 0; got = 0; cyc = 0;
            wait (rnd_go);
            while (got < NBEATS && cyc < 60000) begin
                @(negedge clk);
                ra = RW'($urandom);
                rb = RW'($urandom);
                if ($urandom_range(0, 7) == 0) ra = '1;
                if ($urandom_range(0, 7) == 0) rb = '0;
                rc = 1'($urandom);
                rs = 1'($urandom);
                rif.in_valid  = (sent < NBEATS) && ($urandom_range(0, 3) != 0);
                rif.in_a      = ra;
                rif.in_b      = rb;
                rif.in_cin    = rc;
                rif.in_sub    = rs;
                rif.out_ready = ($urandom_range(0, 3) != 0);
                #2;
                cur_v = {rif.out_valid, rif.out_ovf, rif.out_cout, rif.out_sum};
                if (held) check($sformatf("rnd%0d hold", g), 64'(cur_v), 64'(held_v));
                held   = rif.out_valid && !rif.out_ready;
                held_v = cur_v;
                if (rif.out_valid && rif.out_ready) begin
                    got_v = {rif.out_ovf, rif.out_cout, rif.out_sum};
                    check($sformatf("rnd%0d pending", g), 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        exp_v = exp_q.pop_front();
                        check($sformatf("rnd%0d beat%0d", g, got), 64'(got_v), 64'(exp_v));
                    end
                    got++;
                end
                if (rif.in_valid && rif.in_ready) begin
                    beff    = (SUB_EN && rs) ? ~rb : rb;
                    cin_eff = (SUB_EN && rs) ? 1'b1 : rc;
                    full    = {1'b0, ra} + {1'b0, beff} + {{RW{1'b0}}, cin_eff};
                    ovf     = (ra[RW-1] == beff[RW-1]) && (full[RW-1] != ra[RW-1]);
                    exp_q.push_back({ovf, full});
                    sent++;
                end
                cyc++;
            end
            @(negedge clk);
            rif.in_valid  = 1'b0;
            rif.out_ready = 1'b1;
            check($sformatf("rnd%0d count", g), 64'(got), 64'(NBEATS));
            check($sformatf("rnd%0d leftover", g), 64'(exp_q.size()), 64'd0);
            done_flag = 1'b1;
        end
    end

    task automatic run_beat(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic cin, input logic sub,
                            input logic [15:0] es, input logic ec, input logic eo);
        int lat;
        lat = 0;
        @(negedge clk);
        bif.in_valid  = 1'b1;
        bif.in_a      = a;
        bif.in_b      = b;
        bif.in_cin    = cin;
        bif.in_sub    = sub;
        bif.out_ready = 1'b1;
        #2;
        check({tag, " accept"}, 64'(bif.in_ready), 64'd1);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            bif.in_valid = 1'b0;
            #2;
            if (bif.out_valid) begin
                lat = c;
                break;
            end
        end
        check({tag, " latency"}, 64'(lat), 64'd4);
        check({tag, " sum"}, 64'(bif.out_sum), 64'(es));
        check({tag, " cout"}, 64'(bif.out_cout), 64'(ec));
        check({tag, " ovf"}, 64'(bif.out_ovf), 64'(eo));
    endtask

    task automatic burst_test();
        int          idx, got, lowcnt;
        logic        held;
        logic [18:0] cur_v, held_v;
        idx = 0; got = 0; lowcnt = 0; held = 1'b0; held_v = '0;
        for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
            @(negedge clk);
            bif.out_ready = !(cyc >= 6 && cyc <= 9);
            bif.in_valid  = (idx < 10);
            bif.in_a      = 16'(idx);
            bif.in_b      = 16'h0100;
            bif.in_cin    = 1'b0;
            bif.in_sub    = 1'b0;
            #2;
            cur_v = {bif.out_valid, bif.out_ovf, bif.out_cout, bif.out_sum};
            if (held) check("burst hold", 64'(cur_v), 64'(held_v));
            held   = bif.out_valid && !bif.out_ready;
            held_v = cur_v;
            if (bif.in_valid && !bif.in_ready) lowcnt++;
            if (bif.out_valid && bif.out_ready) begin
                check($sformatf("burst beat%0d", got),
                      64'({bif.out_ovf, bif.out_cout, bif.out_sum}), 64'(18'h00100 + 18'(got)));
                got++;
            end
            if (bif.in_valid && bif.in_ready) idx++;
        end
        @(negedge clk);
        bif.in_valid  = 1'b0;
        bif.out_ready = 1'b1;
        check("burst count", 64'(got), 64'd10);
        check("burst stall cycles", 64'(lowcnt), 64'd4);
        repeat (5) @(negedge clk);
        #2;
        check("burst drained", 64'(bif.out_valid), 64'd0);
    endtask

    task automatic reset_flush_test();
        int seen;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bif.in_valid  = 1'b1;
            bif.in_a      = 16'h1111 * 16'(i + 1);
            bif.in_b      = 16'h0001;
            bif.in_cin    = 1'b0;
            bif.in_sub    = 1'b0;
            bif.out_ready = 1'b1;
            #2;
            check($sformatf("flush accept%0d", i), 64'(bif.in_ready), 64'd1);
        end
        @(negedge clk);
        bif.in_valid = 1'b0;
        rst = 1'b1;
        #2;
        check("flush rst valid", 64'(bif.out_valid), 64'd0);
        check("flush rst data", 64'({bif.out_ovf, bif.out_cout, bif.out_sum}), 64'd0);
        @(negedge clk);
        #2;
        check("flush rst valid2", 64'(bif.out_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #2;
        check("flush ready after rst", 64'(bif.in_ready), 64'd1);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            #2;
            if (bif.out_valid) seen++;
        end
        check("flush no stale beats", 64'(seen), 64'd0);
    endtask

    initial begin : p_watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : p_main
        int wait_cyc;
        n_checks = 0;
        n_errors = 0;
        rnd_go   = 1'b0;
        rst      = 1'b1;
        bif.in_valid  = 1'b0;
        bif.in_a      = '0;
        bif.in_b      = '0;
        bif.in_cin    = 1'b0;
        bif.in_sub    = 1'b0;
        bif.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        #2;
        check("reset out_valid", 64'(bif.out_valid), 64'd0);
        check("reset out_sum", 64'(bif.out_sum), 64'd0);
        check("reset out_cout", 64'(bif.out_cout), 64'd0);
        check("reset out_ovf", 64'(bif.out_ovf), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #2;
        check("ready after reset", 64'(bif.in_ready), 64'd1);

        run_beat("one_plus_one", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);
        run_beat("wrap",         16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_beat("pos_ovf",      16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_beat("neg_ovf",      16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        run_beat("plain_cin",    16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
        if (SUB_EN) begin
            run_beat("sub",     16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
            run_beat("sub_cin", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
            run_beat("sub_eq",  16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
        end else begin
            run_beat("sub",     16'h0005, 16'h0007, 1'b0, 1'b1, 16'h000C, 1'b0, 1'b0);
            run_beat("sub_cin", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'h000D, 1'b0, 1'b0);
            run_beat("sub_eq",  16'h1234, 16'h1234, 1'b0, 1'b1, 16'h2468, 1'b0, 1'b0);
        end

        burst_test();
        reset_flush_test();

        rnd_go   = 1'b1;
        wait_cyc = 0;
        while (!(g_rnd[0].done_flag && g_rnd[1].done_flag && g_rnd[2].done_flag) &&
               wait_cyc < 70000) begin
            @(negedge clk);
            wait_cyc++;
        end
        check("random done", 64'(g_rnd[0].done_flag && g_rnd[1].done_flag && g_rnd[2].done_flag), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
